// File: rtl/mix_matrix_pkg.sv
// Shared types and sizing helpers for the crosspoint mixing matrix.
package mix_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Gain code for 1.0 in Q1.(gainbits-2).
    function automatic int unsigned unity_gain(input int unsigned gainbits);
        return 32'(1) << (gainbits - 2);
    endfunction

    // Four guard bits cover the sum of up to 16 full-scale products.
    function automatic int unsigned acc_width(input int unsigned bitsize,
                                              input int unsigned gainbits);
        return bitsize + gainbits + 4;
    endfunction

endpackage

// File: rtl/mix_matrix_mac.sv
// Signed multiply-accumulate with Q-format shift and output saturation.
module mix_matrix_mac
    import mix_matrix_pkg::*;
#(
    parameter int unsigned BITSIZE  = 16,
    parameter int unsigned GAINBITS = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       en,
    input  logic                       first,
    input  logic signed [BITSIZE-1:0]  sample,
    input  logic signed [GAINBITS-1:0] gain,
    output logic signed [BITSIZE-1:0]  result_c
);

    localparam int unsigned AW    = acc_width(BITSIZE, GAINBITS);
    localparam int unsigned PW    = BITSIZE + GAINBITS;
    localparam int unsigned SHIFT = GAINBITS - 2;

    localparam logic signed [AW-1:0] MAX_C = AW'({1'b0, {(BITSIZE-1){1'b1}}});
    localparam logic signed [AW-1:0] MIN_C = ~MAX_C;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] base_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] shifted_c;

    // First term of each output restarts the sum instead of adding to it.
    always_comb begin
        base_c    = first ? '0 : acc;
        prod_c    = PW'(sample) * PW'(gain);
        sum_c     = base_c + AW'(prod_c);
        shifted_c = sum_c >>> SHIFT;
        if (shifted_c > MAX_C) begin
            result_c = MAX_C[BITSIZE-1:0];
        end else if (shifted_c < MIN_C) begin
            result_c = MIN_C[BITSIZE-1:0];
        end else begin
            result_c = shifted_c[BITSIZE-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/mix_matrix.sv
// N_IN x N_OUT audio mixing matrix: one MAC per cycle, double-buffered gains.
module mix_matrix
    import mix_matrix_pkg::*;
#(
    parameter int unsigned BITSIZE  = 16,
    parameter int unsigned N_IN     = 12,
    parameter int unsigned N_OUT    = 12,
    parameter int unsigned GAINBITS = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sample_strobe,
    input  logic [N_IN*BITSIZE-1:0]    in_bus,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_out,
    input  logic [3:0]                 cfg_in,
    input  logic [GAINBITS-1:0]        cfg_gain,
    input  logic                       cfg_commit,
    output logic [N_OUT*BITSIZE-1:0]   out_bus,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned IW = 4;

    state_t                     state;
    logic [IW-1:0]              o_idx;
    logic [IW-1:0]              i_idx;
    logic signed [BITSIZE-1:0]  snap     [N_IN];
    logic signed [BITSIZE-1:0]  result_q [N_OUT];
    logic signed [GAINBITS-1:0] shadow   [N_OUT][N_IN];
    logic signed [GAINBITS-1:0] active   [N_OUT][N_IN];
    logic                       pending;

    logic                       accept_c;
    logic                       mac_en_c;
    logic                       mac_first_c;
    logic                       last_in_c;
    logic                       wr_ok_c;
    logic signed [BITSIZE-1:0]  mac_result_c;

    assign accept_c    = sample_strobe && (state == IDLE);
    assign mac_en_c    = (state == RUN);
    assign mac_first_c = (i_idx == '0);
    assign last_in_c   = (i_idx == IW'(N_IN - 1));
    assign wr_ok_c     = cfg_we && (32'(cfg_out) < N_OUT) && (32'(cfg_in) < N_IN);

    // Gain storage: the copy reads pre-write shadow values via non-blocking semantics.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
            for (int o = 0; o < int'(N_OUT); o++) begin
                for (int i = 0; i < int'(N_IN); i++) begin
                    shadow[o][i] <= '0;
                    active[o][i] <= '0;
                end
            end
        end else begin
            if (wr_ok_c) begin
                shadow[cfg_out][cfg_in] <= cfg_gain;
            end
            if (accept_c && (pending || cfg_commit)) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (cfg_commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Sequencer: output index outer, input index inner; publish all channels in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            o_idx     <= '0;
            i_idx     <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < int'(N_IN); k++) begin
                snap[k] <= '0;
            end
            for (int o = 0; o < int'(N_OUT); o++) begin
                result_q[o] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (sample_strobe && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        o_idx <= '0;
                        i_idx <= '0;
                        for (int k = 0; k < int'(N_IN); k++) begin
                            snap[k] <= in_bus[k*BITSIZE +: BITSIZE];
                        end
                    end
                end
                RUN: begin
                    if (last_in_c) begin
                        result_q[o_idx] <= mac_result_c;
                        i_idx           <= '0;
                        if (o_idx == IW'(N_OUT - 1)) begin
                            state <= DONE;
                        end else begin
                            o_idx <= o_idx + IW'(1);
                        end
                    end else begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
                DONE: begin
                    for (int o = 0; o < int'(N_OUT); o++) begin
                        out_bus[o*BITSIZE +: BITSIZE] <= result_q[o];
                    end
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mix_matrix_mac #(
        .BITSIZE  (BITSIZE),
        .GAINBITS (GAINBITS)
    ) u_mac (
        .clk      (clk),
        .resetn   (resetn),
        .en       (mac_en_c),
        .first    (mac_first_c),
        .sample   (snap[i_idx]),
        .gain     (active[o_idx][i_idx]),
        .result_c (mac_result_c)
    );

endmodule

// File: doc/mix_matrix.md
MIX_MATRIX -- requirements
Module: mix_matrix

Interface
REQ-001 Parameter BITSIZE, default 16, signed audio sample width.
REQ-002 Parameter N_IN, default 12, input channel count, 2..16.
REQ-003 Parameter N_OUT, default 12, output channel count, 2..16.
REQ-004 Parameter GAINBITS, default 8, signed crosspoint gain width in Q1.(GAINBITS-2) format; unity is 2^(GAINBITS-2).
REQ-005 Port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 Port resetn, input, 1, asynchronous active-low reset.
REQ-007 Port sample_strobe, input, 1, single-cycle pulse marking a new sample period.
REQ-008 Port in_bus, input, N_IN*BITSIZE, signed inputs, channel k at bits [k*BITSIZE +: BITSIZE].
REQ-009 Port cfg_we, input, 1, gain write enable.
REQ-010 Port cfg_out, input, 4, output index of the written crosspoint.
REQ-011 Port cfg_in, input, 4, input index of the written crosspoint.
REQ-012 Port cfg_gain, input, GAINBITS, signed gain value.
REQ-013 Port cfg_commit, input, 1, request to apply shadow gains.
REQ-014 Port out_bus, output, N_OUT*BITSIZE, signed outputs, same packing as in_bus.
REQ-015 Port out_valid, output, 1, one-cycle pulse when out_bus updates.
REQ-016 Port busy, output, 1, high while a mixing pass runs.
REQ-017 Port overrun, output, 1, sticky flag for a strobe received while busy.

Function
REQ-018 Each output SHALL be out[o] = sat(sum over i of in[i]*gain[o][i], arithmetically shifted right by GAINBITS-2).
REQ-019 The accumulator SHALL be BITSIZE+GAINBITS+4 bits wide, with no intermediate wrap.
REQ-020 Saturation SHALL clamp to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
REQ-021 The state machine SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN: on sample_strobe while IDLE.
- RUN to DONE: after the last MAC.
- DONE to IDLE: after one cycle.
REQ-022 In the sample_strobe cycle, in_bus SHALL be captured into a snapshot; later in_bus changes do not affect the pass.
REQ-023 RUN SHALL perform one MAC per cycle, input index inner and output index outer, for N_IN*N_OUT cycles.
REQ-024 Results SHALL collect in an internal buffer; out_bus SHALL update all channels together in DONE, never partially.
REQ-025 out_valid SHALL pulse, and out_bus SHALL change, exactly N_IN*N_OUT+2 cycles after the sample_strobe cycle.
REQ-026 busy SHALL be high from the cycle after the strobe through the DONE cycle.
REQ-027 A sample_strobe while busy SHALL be ignored and SHALL set overrun, which stays set until reset.
REQ-028 cfg_we SHALL write cfg_gain to shadow[cfg_out][cfg_in] in any state.
REQ-029 A write with an index out of range SHALL be discarded.
REQ-030 cfg_commit SHALL set a pending flag; the whole shadow array SHALL copy to the active array in the cycle of the next accepted sample_strobe, before the pass starts.
REQ-031 The gains of a pass SHALL be constant for the whole pass.
REQ-032 If cfg_we and the commit copy occur in the same cycle, the copy SHALL take the pre-write shadow value; the write lands in shadow only.
REQ-033 If cfg_commit coincides with an accepted strobe, that strobe SHALL apply the commit.

Reset
REQ-034 On resetn low, the following SHALL clear asynchronously:
- state to IDLE;
- out_bus, out_valid, busy and overrun to 0;
- the pending commit flag, the shadow gains and the active gains to 0.
REQ-035 A reset during RUN SHALL abandon the pass; out_bus SHALL read 0 with no out_valid pulse.

Structure
REQ-036 Package mix_matrix_pkg SHALL hold the state encoding, the unity-gain function of GAINBITS, and the accumulator width function.
REQ-037 Sub-module mix_matrix_mac SHALL contain the signed multiply, the accumulate, the shift and the saturation.
REQ-038 The top level SHALL contain the sequencer, the gain arrays, the snapshot and the output buffer.

Verification
REQ-039 Reset, then commit with shadow[0][0]=64 (unity), in0=1000, strobe: out0=1000 and the other outputs 0, with out_valid exactly 146 cycles after the strobe (defaults).
REQ-040 gain[3][1]=127 and gain[3][2]=127, in1=in2=32767: out3 saturates to 32767; with inputs -32768 it saturates to -32768.
REQ-041 gain=-64, in=-32768: out=32767 (saturated).
REQ-042 Write gains and strobe without commit: outputs stay 0; after commit, the next strobe applies the new gains.
REQ-043 Strobe at 0, then a second strobe at cycle 50: the second strobe is ignored, overrun=1, and a single out_valid pulse occurs.
REQ-044 Deassert resetn at cycle 80 of a pass: out_valid stays low and all outputs are 0; a following strobe mixes with zero gains.
